// File: rtl/axil_riscv_host_master.sv
// AXI4-Lite master for the RISC-V register slave. Accepts one write or read
// command at a time, runs the matching AXI4-Lite transaction and returns the
// captured response. Defining AXIL_MASTER_POLL_EN adds poll-read support: a
// read is repeated until (rdata & mask) == match or the attempt budget runs out.

module axil_riscv_host_master #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 5,
    parameter int POLL_MAX_BIT         = 16
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_areset,

    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic                                cmd_poll,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_mask,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_match,

    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                rsp_timeout,
    output logic                                busy,

    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int AW = C_M00_AXI_ADDR_WIDTH;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    logic [2:0]      state;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;

`ifdef AXIL_MASTER_POLL_EN
    localparam logic [POLL_MAX_BIT-1:0] POLL_LAST  = '1;
    localparam logic [POLL_MAX_BIT-1:0] POLL_FIRST = POLL_MAX_BIT'(1);

    logic                    poll_q;
    logic [DW-1:0]           mask_q;
    logic [DW-1:0]           match_q;
    logic [POLL_MAX_BIT-1:0] poll_cnt;
    logic                    poll_miss;

    assign poll_miss = (m00_axi_rdata & mask_q) != match_q;
`else
    logic unused_poll_inputs;
    localparam int unused_poll_max_bit = POLL_MAX_BIT;

    assign unused_poll_inputs = ^{cmd_poll, cmd_mask, cmd_match};
    assign rsp_timeout        = 1'b0;
`endif

    // Handshake and status outputs decoded straight from the state; addresses
    // and write data come from the command registers so they stay stable.
    assign cmd_ready       = (state == ST_IDLE) && !m00_axi_areset;
    assign busy            = (state != ST_IDLE);
    assign rsp_valid       = (state == ST_RSP);
    assign m00_axi_bready  = (state == ST_WR_RESP);
    assign m00_axi_rready  = (state == ST_RD_DATA);
    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_arprot  = 3'b000;

    // Command sequencer: accept, issue AW/W or AR, collect B or R, hold response.
    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state           <= ST_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_arvalid <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= 2'b00;
`ifdef AXIL_MASTER_POLL_EN
            poll_q          <= 1'b0;
            mask_q          <= '0;
            match_q         <= '0;
            poll_cnt        <= '0;
            rsp_timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
`ifdef AXIL_MASTER_POLL_EN
                        poll_q      <= cmd_poll && !cmd_write;
                        mask_q      <= cmd_mask;
                        match_q     <= cmd_match;
                        poll_cnt    <= POLL_FIRST;
                        rsp_timeout <= 1'b0;
`endif
                        if (cmd_write) begin
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= ST_WR;
                        end else begin
                            m00_axi_arvalid <= 1'b1;
                            state           <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    m00_axi_awvalid <= m00_axi_awvalid && !m00_axi_awready;
                    m00_axi_wvalid  <= m00_axi_wvalid && !m00_axi_wready;
                    if ((!m00_axi_awvalid || m00_axi_awready) &&
                        (!m00_axi_wvalid || m00_axi_wready)) begin
                        state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m00_axi_bvalid) begin
                        rsp_resp  <= m00_axi_bresp;
                        rsp_rdata <= '0;
                        state     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (m00_axi_arvalid) begin
                        if (m00_axi_arready) begin
                            m00_axi_arvalid <= 1'b0;
                            state           <= ST_RD_DATA;
                        end
                    end else begin
                        m00_axi_arvalid <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (m00_axi_rvalid) begin
                        rsp_rdata <= m00_axi_rdata;
                        rsp_resp  <= m00_axi_rresp;
`ifdef AXIL_MASTER_POLL_EN
                        if (poll_q && (m00_axi_rresp == 2'b00) && poll_miss &&
                            (poll_cnt != POLL_LAST)) begin
                            poll_cnt <= poll_cnt + POLL_FIRST;
                            state    <= ST_RD_ADDR;
                        end else begin
                            rsp_timeout <= poll_q && ((m00_axi_rresp != 2'b00) || poll_miss);
                            state       <= ST_RSP;
                        end
`else
                        state <= ST_RSP;
`endif
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
